sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port arbiter/sequencer in front of the 32 KB byte-wide SPRAM block (15-bit address, 8-bit data, synchronous read).
- Port A is the Z80 bus side. Port B is the loader/config side (SPI image load, readback).
- Owns the SRAM's CS/WE/address/data. Runs a 3-state access FSM. Default policy is fixed priority to A, with a starvation guard for B.

Parameters:
- MAX_A_RUN, 4: consecutive A grants allowed while B is pending before B gets one forced grant. Range 1..15.
- WP_LIMIT, 15'h4000: write-protect boundary. Used only with SRAM_ARB_WP_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held high with a_we/a_addr/a_wdata stable until a_ack
- a_we  in  1  1=write, 0=read
- a_addr  in  15  byte address
- a_wdata  in  8  write data
- a_ack  out  1  one-cycle completion pulse
- a_rdata  out  8  read data, valid while a_ack=1, held until next A read completes
- b_req, b_we, b_addr[15], b_wdata[8], b_ack, b_rdata[8]: same as the port A signals, for port B
- sram_address  out  15  to SRAM address
- sram_datain  out  8  to SRAM write data
- sram_dataout  in  8  from SRAM, valid the cycle after an access cycle
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- busy  out  1  1 whenever FSM is not IDLE
- owner  out  1  0=A, 1=B; port granted for the current/last access
- wp_hit  out  1  one-cycle pulse on a suppressed protected write; constant 0 without the macro

Behaviour:
- Reset (async, rst_n=0) clears every output and register to 0 and puts the FSM in IDLE:
  - a_ack, b_ack, a_rdata, b_rdata, sram_* outputs, busy, owner, wp_hit all 0.
  - Starvation counter is 0.
  - Any access in flight is abandoned without ack.
  - A req still high at reset release is serviced as a new request.
- States:
  - IDLE: sram_cs=0, sram_we=0.
    - If neither req is high, stay in IDLE.
    - Otherwise pick a winner, latch its addr/wdata/we and the owner, go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - sram_cs=1, sram_address/sram_datain from the latched values, sram_we=latched we.
    - Go to DONE.
  - DONE (exactly 1 cycle):
    - sram_cs=0, sram_we=0.
    - For a read, capture sram_dataout into the owner's rdata register.
    - Pulse the owner's ack for this cycle. Go to IDLE.
- Latency: req first high in IDLE cycle n -> ACCESS in n+1 -> ack in n+2 (read data valid in n+2). Minimum spacing between accesses is 3 cycles.
- Handshake:
  - A requester drops req on the edge where it samples ack=1, so the following IDLE cycle sees req low.
  - If req is still high in that IDLE cycle, it is treated as a new request.
  - Changing addr/we/wdata while req=1 before ack is illegal. Only the values latched at grant are used.
- Arbitration, evaluated in IDLE:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting:
    - Grant A, unless the starvation counter is at MAX_A_RUN, in which case grant B.
  - Counter rules:
    - Increments on each A grant made while b_req=1, saturating at MAX_A_RUN.
    - Clears on any B grant.
    - Clears on an IDLE cycle with b_req=0.
- Non-owner ack is never asserted. Both acks are never high together.
- Addresses span the full 15-bit range. Byte-lane and bank selection is handled inside the SRAM block, not here.

Optional Feature:
- Macro: SRAM_ARB_WP_EN.
- Defined:
  - A port-A write with a_addr < WP_LIMIT still runs ACCESS with sram_cs=1 but holds sram_we=0.
  - The SRAM contents are unchanged.
  - a_ack pulses normally, and wp_hit pulses in the same cycle as a_ack.
  - Port B is never write-protected.
- Undefined: no protection, and wp_hit is tied to 0.

Test Plan:
- Reset: rst_n=0 asserted mid-ACCESS -> all outputs 0 immediately, no ack. After release, the held a_req is re-serviced, with ack 2 cycles after the first IDLE.
- A write then A read: write 15'h1234 <- 8'hA5, then read 15'h1234 -> a_ack in n+2 both times, a_rdata=8'hA5, sram_cs high exactly 1 cycle per access.
- B write/read at upper half: b write 15'h7FFF <- 8'h3C, then read -> b_rdata=8'h3C, owner=1, a_ack never asserted.
- Contention: a_req and b_req held continuously with MAX_A_RUN=4 -> grant sequence A,A,A,A,B repeating. Every B wait is 15 cycles or less.
- Simultaneous single requests: a_req and b_req rise together in IDLE -> A granted first (a_ack at n+2), B granted in the next IDLE (b_ack at n+5).
- SRAM_ARB_WP_EN with WP_LIMIT=15'h4000:
  - A write 15'h0100 <- 8'hFF over existing 8'h11 -> a_ack and wp_hit pulse, readback 8'h11.
  - B write to the same address -> stored.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the two requester ports, the SRAM pins and the status flags of
//   sram_arbiter.
//   slave  : the arbiter (drives acks, read data, SRAM controls, status).
//   master : the surrounding system (requesters plus the SRAM macro, which
//            returns sram_dataout).
//   Port A: a_req, a_we, a_addr[15], a_wdata[8] -> a_ack, a_rdata[8]
//   Port B: b_req, b_we, b_addr[15], b_wdata[8] -> b_ack, b_rdata[8]
//   SRAM  : sram_address[15], sram_datain[8], sram_cs, sram_we <- sram_dataout[8]
//   Status: busy, owner (0=A, 1=B), wp_hit
interface sram_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [14:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [14:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;

    logic [14:0] sram_address;
    logic [7:0]  sram_datain;
    logic [7:0]  sram_dataout;
    logic        sram_cs;
    logic        sram_we;

    logic        busy;
    logic        owner;
    logic        wp_hit;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  sram_dataout,
        output a_ack, a_rdata, b_ack, b_rdata,
        output sram_address, sram_datain, sram_cs, sram_we,
        output busy, owner, wp_hit
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output sram_dataout,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  sram_address, sram_datain, sram_cs, sram_we,
        input  busy, owner, wp_hit
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter/sequencer in front of the 32 KB byte-wide SPRAM.
//   Port A (Z80 bus) has fixed priority; port B (loader/config) is given one
//   forced grant after MAX_A_RUN consecutive A grants made while B waited.
//   Every access is IDLE -> ACCESS -> DONE, ack pulses in DONE.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : sram_arbiter_if.slave (requester ports, SRAM pins, status)
//
//   Parameters:
//     MAX_A_RUN : A grants allowed while B is pending before B is forced (1..15)
//     WP_LIMIT  : port-A writes below this address are suppressed when
//                 SRAM_ARB_WP_EN is defined
//
//   Build option:
//     SRAM_ARB_WP_EN : enables port-A write protection and the wp_hit pulse.
//                      Undefined (default): no protection, wp_hit tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | SRAM deselected; arbitrate, latch winner's request
// ACCESS  | one cycle with sram_cs=1 driving the latched request
// DONE    | read data returned by SRAM; ack pulse to the owner
module sram_arbiter #(
    parameter int          MAX_A_RUN = 4,
    parameter logic [14:0] WP_LIMIT  = 15'h4000
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] RUN_MAX = MAX_A_RUN[3:0];

    logic [1:0]  state;
    logic        owner_q;
    logic        we_q;
    logic        wp_q;
    logic [14:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  a_rdata_q;
    logic [7:0]  b_rdata_q;
    logic [3:0]  a_run;

    logic        run_full;
    logic        grant_any;
    logic        grant_b;
    logic        wp_now;
    logic        in_access;
    logic        in_done;
    logic        rd_done;

    assign run_full  = (a_run == RUN_MAX);
    assign grant_any = bus.a_req | bus.b_req;
    // B wins when it is alone, or when A has used up its run while B waited.
    assign grant_b   = bus.b_req & (~bus.a_req | run_full);

`ifdef SRAM_ARB_WP_EN
    assign wp_now = ~grant_b & bus.a_we & (bus.a_addr < WP_LIMIT);
`else
    assign wp_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            wp_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_run     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state   <= ST_ACCESS;
                        owner_q <= grant_b;
                        we_q    <= grant_b ? bus.b_we    : bus.a_we;
                        addr_q  <= grant_b ? bus.b_addr  : bus.a_addr;
                        wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
                        wp_q    <= wp_now;
                    end
                    // Run length only counts A grants that made B wait.
                    if (!bus.b_req || grant_b) begin
                        a_run <= '0;
                    end else if (!run_full) begin
                        a_run <= a_run + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!we_q) begin
                        if (owner_q) begin
                            b_rdata_q <= bus.sram_dataout;
                        end else begin
                            a_rdata_q <= bus.sram_dataout;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_done   = (state == ST_DONE);
    assign rd_done   = in_done & ~we_q;

    assign bus.sram_cs      = in_access;
    // A protected write still selects the array but never strobes we.
    assign bus.sram_we      = in_access & we_q & ~wp_q;
    assign bus.sram_address = addr_q;
    assign bus.sram_datain  = wdata_q;

    assign bus.a_ack = in_done & ~owner_q;
    assign bus.b_ack = in_done &  owner_q;

    // The SRAM returns data during DONE, so the ack cycle forwards it directly;
    // the register holds it afterwards until the same port's next read.
    assign bus.a_rdata = (rd_done & ~owner_q) ? bus.sram_dataout : a_rdata_q;
    assign bus.b_rdata = (rd_done &  owner_q) ? bus.sram_dataout : b_rdata_q;

    assign bus.busy  = (state != ST_IDLE);
    assign bus.owner = owner_q;

`ifdef SRAM_ARB_WP_EN
    assign bus.wp_hit = in_done & wp_q;
`else
    assign bus.wp_hit = 1'b0;
`endif

endmodule
